// File: rtl/xbar_switchbox_pkg.sv
// -----------------------------------------------------------------------------
// xbar_switchbox_pkg
// Shared types and helpers for the row-to-row switchbox.
//   fu_output_t : data word produced by a functional unit (switchbox source)
//   fu_input_t  : operand word consumed by a functional unit (switchbox sink)
//   NUM_FU_COLS : number of FU columns per row (default switchbox fan-in)
//   sb_sel_w()  : select width for a given fan-in
//   sb_fld_w()  : per-output configuration field width {en, sel} for a given
//                 fan-in. Chain-length calculators use this to size the
//                 configuration bitstream of a row.
// -----------------------------------------------------------------------------
package xbar_switchbox_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_FU_COLS = 4;

    typedef logic [DATA_W-1:0] fu_output_t;
    typedef logic [DATA_W-1:0] fu_input_t;

    // A single-source switchbox still carries a 1-bit select so the field
    // layout never degenerates to an enable-only field.
    function automatic int sb_sel_w(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

    function automatic int sb_fld_w(input int num_in);
        return sb_sel_w(num_in) + 1;
    endfunction

endpackage

// File: rtl/xbar_switchbox_sb_out_mux.sv
// -----------------------------------------------------------------------------
// sb_out_mux
// One routed output of the switchbox: decodes its {en, sel} field, selects a
// source word and valid bit, and optionally registers the result.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   fld_i          : active configuration field {en, sel}
//   data_i         : source words from the previous row
//   valid_i        : per-source valid bits
//   out_o          : routed word (0 when disabled or select out of range)
//   out_valid_o    : routed valid (0 when disabled or select out of range)
// -----------------------------------------------------------------------------
module sb_out_mux
    import xbar_switchbox_pkg::*;
#(
    parameter int NUM_IN  = NUM_FU_COLS,
    parameter int SEL_W   = 2,
    parameter int REG_OUT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SEL_W:0]    fld_i,
    input  fu_output_t        data_i [NUM_IN],
    input  logic [NUM_IN-1:0] valid_i,
    output fu_input_t         out_o,
    output logic              out_valid_o
);

    logic             fld_en;
    logic [SEL_W-1:0] fld_sel;
    fu_input_t        mux_data_next;
    logic             mux_valid_next;

    // Compare-and-select rather than a direct index: a select beyond the last
    // source simply matches nothing and leaves the zero default in place.
    always_comb begin
        fld_en         = fld_i[SEL_W];
        fld_sel        = fld_i[SEL_W-1:0];
        mux_data_next  = '0;
        mux_valid_next = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (fld_en && (fld_sel == SEL_W'(i))) begin
                mux_data_next  = data_i[i];
                mux_valid_next = valid_i[i];
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg
        fu_input_t out_reg;
        logic      out_valid_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_reg       <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                out_reg       <= mux_data_next;
                out_valid_reg <= mux_valid_next;
            end
        end

        assign out_o       = out_reg;
        assign out_valid_o = out_valid_reg;
    end else begin : g_comb
        // Clock and reset are not needed on the combinational path.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i | rst_ni;

        assign out_o       = mux_data_next;
        assign out_valid_o = mux_valid_next;
    end

endmodule

// File: rtl/xbar_switchbox.sv
// -----------------------------------------------------------------------------
// xbar_switchbox
// Configurable crossbar between the outputs of one FU row and the operand
// inputs of the next. Configuration is loaded serially into a shadow shift
// register and copied to the active configuration on commit, so a new routing
// can be streamed in while the old one keeps running.
// Ports:
//   clk_i              : clock
//   rst_ni             : asynchronous active-low reset
//   program_en_i       : shift enable for the configuration chain
//   program_data_i     : serial configuration bit in (enters shadow LSB)
//   program_commit_i   : copy pre-edge shadow to active configuration
//   prev_row_outputs_i : source words from the previous row
//   prev_row_valid_i   : per-source valid bits
//   out_o              : routed operand words
//   out_valid_o        : routed valid bits
//   program_data_o     : serial out (shadow MSB), feeds the next switchbox
//   cfg_err_o          : set when the last committed config has an enabled
//                        field selecting a non-existent source
// Config layout: field k = shadow[k*FLD_W +: FLD_W] = {en_k, sel_k}.
// -----------------------------------------------------------------------------
module xbar_switchbox
    import xbar_switchbox_pkg::*;
#(
    parameter int NUM_IN  = NUM_FU_COLS,
    parameter int NUM_OUT = 2,
    parameter int REG_OUT = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               program_en_i,
    input  logic               program_data_i,
    input  logic               program_commit_i,
    input  fu_output_t         prev_row_outputs_i [NUM_IN],
    input  logic [NUM_IN-1:0]  prev_row_valid_i,
    output fu_input_t          out_o [NUM_OUT],
    output logic [NUM_OUT-1:0] out_valid_o,
    output logic               program_data_o,
    output logic               cfg_err_o
);

    localparam int SEL_W = sb_sel_w(NUM_IN);
    localparam int FLD_W = SEL_W + 1;
    localparam int CFG_W = NUM_OUT * FLD_W;

    logic [CFG_W-1:0]   shadow_reg;
    logic [CFG_W-1:0]   shadow_next;
    logic [CFG_W-1:0]   active_reg;
    logic [CFG_W-1:0]   active_next;
    logic               cfg_err_reg;
    logic               cfg_err_next;
    logic [NUM_OUT-1:0] shadow_illegal;

    // Legality is judged on the shadow contents, since that is exactly what a
    // commit on this edge will load into the active configuration.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chk
        assign shadow_illegal[gi] = shadow_reg[gi*FLD_W + SEL_W] &&
                                    (int'(shadow_reg[gi*FLD_W +: SEL_W]) >= NUM_IN);
    end

    // Commit samples the pre-edge shadow, so a shift on the same edge does not
    // leak its new bit into the active configuration.
    always_comb begin
        shadow_next  = program_en_i ? {shadow_reg[CFG_W-2:0], program_data_i} : shadow_reg;
        active_next  = program_commit_i ? shadow_reg : active_reg;
        cfg_err_next = program_commit_i ? (|shadow_illegal) : cfg_err_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    assign program_data_o = shadow_reg[CFG_W-1];
    assign cfg_err_o      = cfg_err_reg;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
        sb_out_mux #(
            .NUM_IN  (NUM_IN),
            .SEL_W   (SEL_W),
            .REG_OUT (REG_OUT)
        ) u_mux (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .fld_i       (active_reg[gi*FLD_W +: FLD_W]),
            .data_i      (prev_row_outputs_i),
            .valid_i     (prev_row_valid_i),
            .out_o       (out_o[gi]),
            .out_valid_o (out_valid_o[gi])
        );
    end

endmodule

// File: tb/tb_xbar_switchbox.sv
// -----------------------------------------------------------------------------
// tb_xbar_switchbox
// Three instances: u_a (4 sources, registered) chained serially into u_b
// (4 sources, combinational), and an independent u_c (3 sources, registered)
// for out-of-range selects. Inputs change after the falling edge; outputs are
// sampled on the falling edge. Expectations go into a queue when stimulus is
// applied and are popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_xbar_switchbox;
    import xbar_switchbox_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pen_ab, pdi_a, pcm_a, pcm_b;
    logic       pen_c, pdi_c, pcm_c;
    fu_output_t in_a [4];
    fu_output_t in_b [4];
    fu_output_t in_c [3];
    logic [3:0] v_a, v_b;
    logic [2:0] v_c;
    fu_input_t  out_a [2];
    fu_input_t  out_b [2];
    fu_input_t  out_c [2];
    logic [1:0] ov_a, ov_b, ov_c;
    logic       pdo_a, pdo_b, pdo_c;
    logic       err_a, err_b, err_c;

    xbar_switchbox #(.NUM_IN(4), .NUM_OUT(2), .REG_OUT(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .program_en_i(pen_ab), .program_data_i(pdi_a), .program_commit_i(pcm_a),
        .prev_row_outputs_i(in_a), .prev_row_valid_i(v_a),
        .out_o(out_a), .out_valid_o(ov_a),
        .program_data_o(pdo_a), .cfg_err_o(err_a)
    );

    xbar_switchbox #(.NUM_IN(4), .NUM_OUT(2), .REG_OUT(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .program_en_i(pen_ab), .program_data_i(pdo_a), .program_commit_i(pcm_b),
        .prev_row_outputs_i(in_b), .prev_row_valid_i(v_b),
        .out_o(out_b), .out_valid_o(ov_b),
        .program_data_o(pdo_b), .cfg_err_o(err_b)
    );

    xbar_switchbox #(.NUM_IN(3), .NUM_OUT(2), .REG_OUT(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n),
        .program_en_i(pen_c), .program_data_i(pdi_c), .program_commit_i(pcm_c),
        .prev_row_outputs_i(in_c), .prev_row_valid_i(v_c),
        .out_o(out_c), .out_valid_o(ov_c),
        .program_data_o(pdo_c), .cfg_err_o(err_c)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed=%0h required=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e.val) begin
            $display("[TB] %-14s observed=%0h expected=%0h", e.tag, obs, e.val);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic shift_a(input logic b);
        pen_ab = 1'b1;
        pdi_a  = b;
        @(negedge clk);
        pen_ab = 1'b0;
    endtask

    task automatic shift_c(input logic b);
        pen_c = 1'b1;
        pdi_c = b;
        @(negedge clk);
        pen_c = 1'b0;
    endtask

    task automatic load_a(input logic [5:0] cfg);
        for (int i = 5; i >= 0; i--) shift_a(cfg[i]);
    endtask

    task automatic load_c(input logic [5:0] cfg);
        for (int i = 5; i >= 0; i--) shift_c(cfg[i]);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pat;

        rst_n = 1'b0;
        pen_ab = 1'b0; pdi_a = 1'b0; pcm_a = 1'b0; pcm_b = 1'b0;
        pen_c = 1'b0; pdi_c = 1'b0; pcm_c = 1'b0;
        in_a = '{16'd10, 16'd20, 16'd30, 16'd40};
        in_b = '{16'd100, 16'd200, 16'd300, 16'd400};
        in_c = '{16'd7, 16'd8, 16'd9};
        v_a = 4'b1111;
        v_b = 4'b1000;
        v_c = 3'b111;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        expect_val("rst_out_a", 64'd0);   check({out_a[1], out_a[0]});
        expect_val("rst_valid_a", 64'd0); check(ov_a);
        expect_val("rst_pdo_a", 64'd0);   check(pdo_a);
        expect_val("rst_err_c", 64'd0);   check(err_c);
        rst_n = 1'b1;
        @(negedge clk);

        // out1={1,10}, out0={1,01}; first bit shifted ends up as the MSB
        load_a(6'b110_101);
        pcm_a = 1'b1;
        expect_val("commit_lat_a", 64'd0);
        @(negedge clk);
        pcm_a = 1'b0;
        check({out_a[1], out_a[0]});
        expect_val("route_a", {32'd0, 16'd30, 16'd20});
        expect_val("route_va", 64'd3);
        @(negedge clk);
        check({out_a[1], out_a[0]});
        check(ov_a);
        expect_val("err_a_legal", 64'd0); check(err_a);

        // New config streamed in without commit: routing unchanged
        load_a(6'b111_100);
        expect_val("shadow_hold", {32'd0, 16'd30, 16'd20});
        check({out_a[1], out_a[0]});
        pcm_a = 1'b1;
        expect_val("commit_edge", {32'd0, 16'd30, 16'd20});
        @(negedge clk);
        pcm_a = 1'b0;
        check({out_a[1], out_a[0]});
        expect_val("new_route", {32'd0, 16'd40, 16'd10});
        @(negedge clk);
        check({out_a[1], out_a[0]});

        // Shadow 111100 -> 100010 after three shifts, then shift+commit together
        shift_a(1'b0); shift_a(1'b1); shift_a(1'b0);
        expect_val("pdo_pre", 64'd1); check(pdo_a);
        pen_ab = 1'b1; pdi_a = 1'b1; pcm_a = 1'b1;
        @(negedge clk);
        pen_ab = 1'b0; pcm_a = 1'b0;
        expect_val("pdo_post", 64'd0); check(pdo_a);
        expect_val("simul_edge", {32'd0, 16'd40, 16'd10});
        check({out_a[1], out_a[0]});
        expect_val("simul_route", {32'd0, 16'd10, 16'd0});
        expect_val("simul_valid", 64'd2);
        @(negedge clk);
        check({out_a[1], out_a[0]});
        check(ov_a);

        // u_b shadow now 011111 (fed from u_a); combinational commit
        expect_val("comb_pre", 64'd0); check({out_b[1], out_b[0]});
        pcm_b = 1'b1;
        expect_val("comb_commit", {32'd0, 16'd0, 16'd400});
        expect_val("comb_valid", 64'd1);
        @(negedge clk);
        pcm_b = 1'b0;
        check({out_b[1], out_b[0]});
        check(ov_b);

        // Three-source instance: field1 selects source 3 (does not exist)
        load_c(6'b111_100);
        pcm_c = 1'b1;
        expect_val("err_set", 64'd1);
        @(negedge clk);
        pcm_c = 1'b0;
        check(err_c);
        expect_val("illegal_data", {32'd0, 16'd0, 16'd7});
        expect_val("illegal_valid", 64'd1);
        @(negedge clk);
        check({out_c[1], out_c[0]});
        check(ov_c);
        load_c(6'b101_000);
        pcm_c = 1'b1;
        expect_val("err_clear", 64'd0);
        @(negedge clk);
        pcm_c = 1'b0;
        check(err_c);
        expect_val("legal_data", {32'd0, 16'd8, 16'd0});
        expect_val("legal_valid", 64'd2);
        @(negedge clk);
        check({out_c[1], out_c[0]});
        check(ov_c);

        // 12-bit pattern through u_a -> u_b
        pat = 12'b1011_0011_1001;
        for (int c = 0; c < 24; c++) begin
            if (c >= 12) check(pdo_b);
            pen_ab = 1'b1;
            pdi_a  = (c < 12) ? pat[11-c] : 1'b0;
            if (c < 12) expect_val($sformatf("chain_bit%0d", c), {63'd0, pat[11-c]});
            @(negedge clk);
        end
        pen_ab = 1'b0;

        // Leave an error flag set on u_c before the reset pulse
        load_c(6'b111_000);
        pcm_c = 1'b1;
        expect_val("err_reset_pre", 64'd1);
        @(negedge clk);
        pcm_c = 1'b0;
        check(err_c);
        expect_val("pre_rst_out_a", {32'd0, 16'd10, 16'd0});
        check({out_a[1], out_a[0]});

        // Short reset pulse in the middle of a programming burst
        shift_a(1'b1); shift_a(1'b1);
        pen_ab = 1'b1; pdi_a = 1'b1;
        #2;
        rst_n = 1'b0;
        pen_ab = 1'b0;
        #1;
        expect_val("arst_out_a", 64'd0);  check({out_a[1], out_a[0]});
        expect_val("arst_va", 64'd0);     check(ov_a);
        expect_val("arst_out_b", 64'd0);  check({out_b[1], out_b[0]});
        expect_val("arst_vb", 64'd0);     check(ov_b);
        expect_val("arst_err_c", 64'd0);  check(err_c);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("post_pdo_a", 64'd0);  check(pdo_a);
        expect_val("post_out_a", 64'd0);  check({out_a[1], out_a[0]});
        pcm_a = 1'b1;
        @(negedge clk);
        pcm_a = 1'b0;
        expect_val("stale_err_a", 64'd0); check(err_a);
        @(negedge clk);
        expect_val("stale_out_a", 64'd0); check({out_a[1], out_a[0]});
        expect_val("stale_va", 64'd0);    check(ov_a);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
